// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALWB,
        S_TRAP
    } state_t;

    // How the ALU decoder should pick the operation in the current state.
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_FUNCT
    } alu_cls_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: maps the state class and funct fields to ALUctrl
// and flags funct3 values the core does not implement.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  alu_cls_t   cls,
    output logic [2:0] alu_ctrl,
    output logic       alu_illegal
);

    // Select the ALU operation; funct7_5 only means subtract for R-type,
    // for I-type that bit belongs to the immediate.
    always_comb begin
        alu_ctrl    = ALU_ADD;
        alu_illegal = 1'b0;
        case (cls)
            ALU_CLS_SUB: alu_ctrl = ALU_SUB;
            ALU_CLS_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctrl = (op == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_illegal = 1'b1;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control FSM for the RV32I core: drives all datapath selects
// and enables, handles the memory handshake with a wait-cycle timeout, and
// parks in TRAP with sticky flags on bus errors or unsupported instructions.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       EQ,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUctrl,
    output logic [1:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic       bus_err,
    output logic       illegal
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] wait_cnt_reg;
    logic          bus_err_reg, illegal_reg;
    logic          set_bus_err, set_illegal;
    logic          timeout_hit;
    alu_cls_t      alu_cls;
    logic [2:0]    alu_ctrl_dec;
    logic          alu_illegal;

    assign timeout_hit = (wait_cnt_reg == LAST_WAIT);
    assign bus_err     = bus_err_reg;
    assign illegal     = illegal_reg;

    // Tell the ALU decoder which kind of operation this state performs.
    always_comb begin
        alu_cls = ALU_CLS_ADD;
        case (state_reg)
            S_EXEC_R, S_EXEC_I: alu_cls = ALU_CLS_FUNCT;
            S_BRANCH:           alu_cls = ALU_CLS_SUB;
            default:            alu_cls = ALU_CLS_ADD;
        endcase
    end

    mc_alu_dec u_alu_dec (
        .op          (Op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .cls         (alu_cls),
        .alu_ctrl    (alu_ctrl_dec),
        .alu_illegal (alu_illegal)
    );

    // Next-state and output decode; everything is forced low while in reset.
    always_comb begin
        state_next  = state_reg;
        set_bus_err = 1'b0;
        set_illegal = 1'b0;
        mem_req     = 1'b0;
        MemWrite    = 1'b0;
        AdrSrc      = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        ImmSrc      = IMM_I;
        ResultSrc   = RES_ALUOUT;
        ALUctrl     = alu_ctrl_dec;
        case (state_reg)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next  = S_TRAP;
                    set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (Op == OP_JAL) ? IMM_J : IMM_B;
                case (Op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXEC_R;
                    OP_I:         state_next = S_EXEC_I;
                    OP_BR:        state_next = S_BRANCH;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        state_next  = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = (Op == OP_SW) ? IMM_S : IMM_I;
                state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD, S_MEMWR: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = (state_reg == S_MEMWR);
                if (mem_ready) begin
                    state_next = (state_reg == S_MEMWR) ? S_FETCH : S_MEMWB;
                end else if (timeout_hit) begin
                    state_next  = S_TRAP;
                    set_bus_err = 1'b1;
                end
            end
            S_MEMWB: begin
                ResultSrc  = RES_RDATA;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = (state_reg == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
                ImmSrc  = IMM_I;
                if (alu_illegal) begin
                    state_next  = S_TRAP;
                    set_illegal = 1'b1;
                end else begin
                    state_next = S_ALUWB;
                end
            end
            S_ALUWB, S_JALWB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ResultSrc  = RES_ALUOUT;
                state_next = S_FETCH;
                case (funct3)
                    3'b000:  PCWrite = EQ;
                    3'b001:  PCWrite = !EQ;
                    default: begin
                        state_next  = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_JAL: begin
                ResultSrc  = RES_ALUOUT;
                PCWrite    = 1'b1;
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                state_next = S_JALWB;
            end
            default: state_next = S_TRAP;
        endcase
        if (!rst) begin
            mem_req   = 1'b0;
            MemWrite  = 1'b0;
            AdrSrc    = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b00;
            ALUctrl   = 3'b000;
            ImmSrc    = 2'b00;
            ResultSrc = 2'b00;
        end
    end

    // State, wait counter and sticky flags; the counter restarts on every
    // state change so each access gets its own timeout budget.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            bus_err_reg  <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) begin
                wait_cnt_reg <= '0;
            end else if (mem_req && !mem_ready) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            bus_err_reg <= bus_err_reg | set_bus_err;
            illegal_reg <= illegal_reg | set_illegal;
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: a per-instruction behavioural model
// expands each instruction into its expected cycle-by-cycle control vector,
// and a single driver/compare loop checks the DUT against it every cycle.
module tb_mc_sequencer;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        EQ = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]  ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
    logic [2:0]  ALUctrl;
    logic        bus_err, illegal;

    always #5 clk = ~clk;

    mc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .Op        (instr[6:0]),
        .funct3    (instr[14:12]),
        .funct7_5  (instr[30]),
        .EQ        (EQ),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .MemWrite  (MemWrite),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUctrl   (ALUctrl),
        .ImmSrc    (ImmSrc),
        .ResultSrc (ResultSrc),
        .bus_err   (bus_err),
        .illegal   (illegal)
    );

    // Observed vector layout: [18]mem_req [17]MemWrite [16]AdrSrc [15]IRWrite
    // [14]PCWrite [13]RegWrite [12:11]A [10:9]B [8:6]ALU [5:4]Imm [3:2]Res [1]bus_err [0]illegal
    logic [18:0] outs;
    assign outs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                   ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, ResultSrc, bus_err, illegal};

    typedef struct {
        logic [31:0] ins;
        logic        rdy;
        logic        eq;
        logic [18:0] exp;
    } step_t;

    step_t       q[$];
    logic [18:0] lg[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        m_bus = 1'b0;
    logic        m_ill = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [18:0] ov(input logic mreq, mw, adr, irw, pcw, rw,
                                       input logic [1:0] a, b, input logic [2:0] alu,
                                       input logic [1:0] imm, res);
        return {mreq, mw, adr, irw, pcw, rw, a, b, alu, imm, res, m_bus, m_ill};
    endfunction

    task automatic push(input logic [31:0] ins, input logic rdy, input logic eq, input logic [18:0] e);
        step_t s;
        s.ins = ins; s.rdy = rdy; s.eq = eq; s.exp = e;
        q.push_back(s);
    endtask

    // A memory access of w wait cycles, or a timeout when w reaches TIMEOUT.
    task automatic add_mem(input logic [31:0] ins, input logic eq, input int w,
                           input logic [18:0] wait_v, input logic [18:0] done_v, output bit ok);
        int n;
        n = (w >= TIMEOUT) ? TIMEOUT : w;
        for (int i = 0; i < n; i++) push(ins, 1'b0, eq, wait_v);
        if (w >= TIMEOUT) begin
            ok = 1'b0;
            m_bus = 1'b1;
        end else begin
            push(ins, 1'b1, eq, done_v);
            ok = 1'b1;
        end
    endtask

    // Trap is absorbing: nothing asserted even with mem_ready high.
    task automatic add_trap(input logic [31:0] ins, input logic eq);
        for (int i = 0; i < 4; i++)
            push(ins, 1'b1, eq, ov(0,0,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,2'b00));
    endtask

    // {bad, alu op} for a funct3 in an ALU instruction.
    function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return {1'b0, sub ? 3'b001 : 3'b000};
            3'b010:  return {1'b0, 3'b101};
            3'b110:  return {1'b0, 3'b011};
            3'b111:  return {1'b0, 3'b010};
            default: return {1'b1, 3'b000};
        endcase
    endfunction

    task automatic build(input logic [31:0] ins, input logic eq, input int fw, input int dw);
        logic [6:0] op;
        logic [2:0] f3;
        logic [3:0] ar;
        logic       pcw, is_sw;
        bit         ok;
        op = ins[6:0];
        f3 = ins[14:12];
        add_mem(ins, eq, fw, ov(1,0,0,0,0,0, 2'b00,2'b10,3'b000,2'b00,2'b10),
                ov(1,0,0,1,1,0, 2'b00,2'b10,3'b000,2'b00,2'b10), ok);
        if (!ok) begin add_trap(ins, eq); return; end
        push(ins, 1'b0, eq, ov(0,0,0,0,0,0, 2'b01,2'b01,3'b000,
                               (op == 7'b1101111) ? 2'b11 : 2'b10, 2'b00));
        case (op)
            7'b0000011, 7'b0100011: begin
                is_sw = (op == 7'b0100011);
                push(ins, 1'b0, eq, ov(0,0,0,0,0,0, 2'b10,2'b01,3'b000, is_sw ? 2'b01 : 2'b00, 2'b00));
                add_mem(ins, eq, dw, ov(1,is_sw,1,0,0,0, 2'b00,2'b00,3'b000,2'b00,2'b00),
                        ov(1,is_sw,1,0,0,0, 2'b00,2'b00,3'b000,2'b00,2'b00), ok);
                if (!ok) begin add_trap(ins, eq); return; end
                if (!is_sw) push(ins, 1'b0, eq, ov(0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b00,2'b01));
            end
            7'b0110011, 7'b0010011: begin
                ar = f3_alu(f3, (op == 7'b0110011) && ins[30]);
                push(ins, 1'b0, eq, ov(0,0,0,0,0,0, 2'b10, (op == 7'b0010011) ? 2'b01 : 2'b00,
                                       ar[2:0], 2'b00, 2'b00));
                if (ar[3]) begin m_ill = 1'b1; add_trap(ins, eq); return; end
                push(ins, 1'b0, eq, ov(0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b00,2'b00));
            end
            7'b1100011: begin
                pcw = (f3 == 3'b000) ? eq : (f3 == 3'b001) ? !eq : 1'b0;
                push(ins, 1'b0, eq, ov(0,0,0,0,pcw,0, 2'b10,2'b00,3'b001,2'b00,2'b00));
                if (f3 > 3'b001) begin m_ill = 1'b1; add_trap(ins, eq); return; end
            end
            7'b1101111: begin
                push(ins, 1'b0, eq, ov(0,0,0,0,1,0, 2'b01,2'b10,3'b000,2'b00,2'b00));
                push(ins, 1'b0, eq, ov(0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b00,2'b00));
            end
            default: begin
                m_ill = 1'b1;
                add_trap(ins, eq);
            end
        endcase
    endtask

    // Drive each step, let outputs settle, compare, then advance to the next negedge.
    task automatic run_steps(input int limit);
        step_t s;
        int    k;
        k = 0;
        while (q.size() > 0 && (limit < 0 || k < limit)) begin
            s = q.pop_front();
            instr = s.ins; mem_ready = s.rdy; EQ = s.eq;
            #1;
            chk($sformatf("cycle%0d_instr_%h", k, s.ins), {13'b0, outs}, {13'b0, s.exp});
            lg.push_back(outs);
            k++;
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic eq, input int fw, input int dw);
        lg.delete();
        build(ins, eq, fw, dw);
        run_steps(-1);
        $display("txn instr=%h eq=%0d fetch_wait=%0d data_wait=%0d cycles=%0d", ins, eq, fw, dw, lg.size());
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1 chk("reset_outputs_a", {13'b0, outs}, 32'h0);
        @(negedge clk);
        #1 chk("reset_outputs_b", {13'b0, outs}, 32'h0);
        m_bus = 1'b0;
        m_ill = 1'b0;
        rst = 1'b1;
    endtask

    int cnt_a, cnt_b;

    initial begin
        reset_dut();

        // addi x1,x0,5: model pinned to 4 cycles, then run
        build(32'h00500093, 1'b0, 0, 0);
        chk("model_addi_len", q.size(), 4);
        q.delete();
        run_instr(32'h00500093, 1'b0, 0, 0);
        chk("addi_len", lg.size(), 4);
        chk("addi_c1_memreq", lg[0][18], 1);
        chk("addi_c4_regwrite", lg[3][13], 1);
        chk("addi_c4_aluctrl", lg[3][8:6], 0);

        // lw with 3 wait cycles in MEMRD
        run_instr(32'h0000A103, 1'b0, 0, 3);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < lg.size(); i++) begin
            if (lg[i][18] && lg[i][16]) cnt_a++;
            if (lg[i][13]) cnt_b++;
        end
        chk("lw_memreq_adrsrc_cycles", cnt_a, 4);
        chk("lw_regwrite_count", cnt_b, 1);
        chk("lw_wb_resultsrc", lg[lg.size()-1][3:2], 2'b01);

        run_instr(32'h00208463, 1'b1, 0, 0);           // beq, EQ=1
        chk("beq_eq1_pcwrite", lg[2][14], 1);
        run_instr(32'h00209463, 1'b1, 0, 0);           // bne, EQ=1
        chk("bne_eq1_pcwrite", lg[2][14], 0);
        run_instr(32'h00208463, 1'b0, 0, 0);           // beq, EQ=0
        run_instr(32'h00209463, 1'b0, 2, 0);           // bne, EQ=0, slow fetch

        run_instr(32'h402081B3, 1'b0, 0, 0);           // sub
        chk("sub_aluctrl", lg[2][8:6], 3'b001);
        run_instr(32'h002081B3, 1'b0, 0, 0);           // add
        run_instr(32'h0020E1B3, 1'b0, 0, 0);           // or
        run_instr(32'h0020F1B3, 1'b0, 0, 0);           // and
        run_instr(32'h0020A1B3, 1'b0, 0, 0);           // slt
        run_instr(32'h0070F093, 1'b0, 0, 0);           // andi
        run_instr(32'h0070A093, 1'b0, 0, 0);           // slti
        run_instr(32'h0070E093, 1'b0, 0, 0);           // ori
        run_instr(32'hC0000093, 1'b0, 0, 0);           // addi with imm bit30 set: still add
        run_instr(32'h010000EF, 1'b0, 1, 0);           // jal
        run_instr(32'h0020A223, 1'b0, 0, 2);           // sw, 2 waits
        run_instr(32'h0000A103, 1'b0, TIMEOUT-1, 0);   // lw, mem_ready in last allowed cycle
        chk("last_wait_no_buserr", lg[lg.size()-1][1], 0);

        // Unsupported opcode
        run_instr(32'h0000007F, 1'b0, 0, 0);
        chk("illegal_flag", lg[lg.size()-1][0], 1);
        cnt_a = 0;
        for (int i = 2; i < lg.size(); i++) if (lg[i][18:13] != 6'b0) cnt_a++;
        chk("illegal_no_enables", cnt_a, 0);

        reset_dut();
        run_instr(32'h002091B3, 1'b0, 0, 0);           // R-type funct3=001 -> trap
        reset_dut();
        run_instr(32'h0020A463, 1'b1, 0, 0);           // branch funct3=010 -> trap

        // Fetch timeout
        reset_dut();
        run_instr(32'h00500093, 1'b0, TIMEOUT, 0);
        cnt_a = 0;
        for (int i = 0; i < lg.size(); i++) if (lg[i][18]) cnt_a++;
        chk("timeout_memreq_cycles", cnt_a, TIMEOUT);
        chk("timeout_buserr_c17", lg[TIMEOUT][1], 1);
        chk("timeout_memreq_c17", lg[TIMEOUT][18], 0);

        // Asynchronous reset in the middle of a store
        reset_dut();
        lg.delete();
        build(32'h0020A223, 1'b0, 0, 10);
        run_steps(5);
        q.delete();
        mem_ready = 1'b0;
        #1 chk("memwr_before_reset", {30'b0, mem_req, MemWrite}, 32'h3);
        #1 rst = 1'b0;
        #1 chk("async_reset_memreq", mem_req, 0);
        chk("async_reset_memwrite", MemWrite, 0);
        @(negedge clk);
        m_bus = 1'b0;
        m_ill = 1'b0;
        #1 chk("async_reset_hold", {13'b0, outs}, 32'h0);
        rst = 1'b1;
        run_instr(32'h00500093, 1'b0, 0, 0);
        chk("after_reset_flags", lg[0][1:0], 2'b00);
        $display("txn async reset mid-store done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
